// File: rtl/alu_exec.sv
// RV32I integer execute unit: single-cycle add/sub/logic/compare and an
// iterative one-bit-per-cycle shifter, returned over a valid/ready handshake.
module alu_exec #(
  parameter int REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                alu_op,
  input  logic [2:0]                funct3,
  input  logic [6:0]                funct7,
  input  logic [REG_DATA_WIDTH-1:0] in_a,
  input  logic [REG_DATA_WIDTH-1:0] in_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REG_DATA_WIDTH-1:0] result,
  output logic                      zero,
  output logic                      illegal
);

  localparam int W  = REG_DATA_WIDTH;
  localparam int SW = $clog2(REG_DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
    OP_SRL, OP_SRA, OP_OR, OP_AND, OP_ILL
  } op_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shk_t;

  state_t         state;
  op_t            dec;
  shk_t           dec_shk;
  shk_t           shk;
  logic [W-1:0]   value;
  logic [W-1:0]   shreg;
  logic [W-1:0]   sh_next;
  logic [SW-1:0]  cnt;
  logic [SW-1:0]  sh_amt;
  logic           is_shift;

  assign sh_amt    = in_b[SW-1:0];
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    dec = OP_ILL;
    unique case (alu_op)
      2'b00: dec = OP_ADD;
      2'b01: dec = OP_SUB;
      2'b10: begin
        if (funct7 == 7'b0000000) begin
          unique case (funct3)
            3'b000: dec = OP_ADD;
            3'b001: dec = OP_SLL;
            3'b010: dec = OP_SLT;
            3'b011: dec = OP_SLTU;
            3'b100: dec = OP_XOR;
            3'b101: dec = OP_SRL;
            3'b110: dec = OP_OR;
            3'b111: dec = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      dec = OP_SUB;
          else if (funct3 == 3'b101) dec = OP_SRA;
        end
      end
      2'b11: begin
        // funct7 is immediate bits here; it only qualifies the shift forms
        unique case (funct3)
          3'b000: dec = OP_ADD;
          3'b001: if (funct7 == 7'b0000000) dec = OP_SLL;
          3'b010: dec = OP_SLT;
          3'b011: dec = OP_SLTU;
          3'b100: dec = OP_XOR;
          3'b101: begin
            if (funct7 == 7'b0000000)      dec = OP_SRL;
            else if (funct7 == 7'b0100000) dec = OP_SRA;
          end
          3'b110: dec = OP_OR;
          3'b111: dec = OP_AND;
        endcase
      end
    endcase
  end

  always_comb begin
    value    = '0;
    is_shift = 1'b0;
    dec_shk  = SH_LL;
    case (dec)
      OP_ADD:  value = in_a + in_b;
      OP_SUB:  value = in_a - in_b;
      OP_SLT:  value = {{(W-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: value = {{(W-1){1'b0}}, (in_a < in_b)};
      OP_XOR:  value = in_a ^ in_b;
      OP_OR:   value = in_a | in_b;
      OP_AND:  value = in_a & in_b;
      OP_SLL:  begin value = in_a; is_shift = 1'b1; dec_shk = SH_LL; end
      OP_SRL:  begin value = in_a; is_shift = 1'b1; dec_shk = SH_RL; end
      OP_SRA:  begin value = in_a; is_shift = 1'b1; dec_shk = SH_RA; end
      default: value = '0;
    endcase
  end

  always_comb begin
    sh_next = shreg;
    case (shk)
      SH_LL:   sh_next = {shreg[W-2:0], 1'b0};
      SH_RL:   sh_next = {1'b0, shreg[W-1:1]};
      default: sh_next = {shreg[W-1], shreg[W-1:1]};
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= IDLE;
      result  <= '0;
      zero    <= 1'b1;
      illegal <= 1'b0;
      shreg   <= '0;
      cnt     <= '0;
      shk     <= SH_LL;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (is_shift && (sh_amt != '0)) begin
              shreg <= in_a;
              cnt   <= sh_amt;
              shk   <= dec_shk;
              state <= SHIFT;
            end else begin
              result  <= value;
              zero    <= (value == '0);
              illegal <= (dec == OP_ILL);
              state   <= DONE;
            end
          end
        end
        SHIFT: begin
          shreg <= sh_next;
          cnt   <= cnt - SW'(1);
          if (cnt == SW'(1)) begin
            result  <= sh_next;
            zero    <= (sh_next == '0);
            illegal <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Randomized and directed checks of alu_exec against an arithmetic reference model.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int vectors = 0;
  int fails   = 0;

  alu_exec #(.REG_DATA_WIDTH(32)) dut (
    .clk(clk), .nreset(nreset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7(funct7), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ext = cycles spent shifting before out_valid; non-shift ops show out_valid
  // in the cycle right after acceptance.
  function automatic void model(input logic [1:0] op, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] res,
                                output logic ill, output int ext);
    int n;
    logic base, alt;
    logic signed [31:0] sa;
    n    = int'(b[4:0]);
    base = (f7 == 7'h00);
    alt  = (f7 == 7'h20);
    sa   = a;
    ill  = 1'b0;
    ext  = 0;
    res  = '0;
    if (op == 2'd0) res = a + b;
    else if (op == 2'd1) res = a - b;
    else begin
      if (op == 2'd2) ill = !(base || (alt && (f3 == 3'd0 || f3 == 3'd5)));
      else            ill = (f3 == 3'd1 && !base) || (f3 == 3'd5 && !base && !alt);
      if (!ill) begin
        case (f3)
          3'd0: res = (op == 2'd2 && alt) ? a - b : a + b;
          3'd1: begin res = a << n; ext = n; end
          3'd2: res = (sa < $signed(b)) ? 32'd1 : 32'd0;
          3'd3: res = (a < b) ? 32'd1 : 32'd0;
          3'd4: res = a ^ b;
          3'd5: begin
            if (alt) res = sa >>> n;
            else     res = a >> n;
            ext = n;
          end
          3'd6: res = a | b;
          default: res = a & b;
        endcase
      end
    end
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic        ei;
    int          ext;
    int          lat;
    model(op, f3, f7, a, b, er, ei, ext);
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    alu_op = op; funct3 = f3; funct7 = f7; in_a = a; in_b = b;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_op = 2'($urandom); funct3 = 3'($urandom); funct7 = 7'($urandom);
    in_a = $urandom; in_b = $urandom;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(ext));
    check("result", result, er);
    check("zero", 32'(zero), 32'(er == 32'd0));
    check("illegal", 32'(illegal), 32'(ei));
    check("in_ready_busy", 32'(in_ready), 32'd0);
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_result", result, er);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid), 32'd0);
    check("in_ready_back", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic seen;
    logic [6:0] f7r;
    logic [31:0] br;

    // reset
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_illegal", 32'(illegal), 32'd0);
    @(negedge clk); nreset = 1'b1;

    // directed cases
    run_op(2'b10, 3'b000, 7'h20, 32'd5, 32'd7, 0);
    run_op(2'b10, 3'b101, 7'h20, 32'h8000_0000, 32'd4, 0);
    run_op(2'b10, 3'b101, 7'h00, 32'h8000_0000, 32'd4, 0);
    run_op(2'b11, 3'b001, 7'h00, 32'd1, 32'h1F, 0);
    run_op(2'b11, 3'b001, 7'h00, 32'd1, 32'h20, 0);
    run_op(2'b10, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(2'b10, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(2'b10, 3'b000, 7'h01, 32'd9, 32'd3, 0);
    run_op(2'b11, 3'b001, 7'h20, 32'd9, 32'd3, 0);
    run_op(2'b00, 3'b111, 7'h7F, 32'hFFFF_FFFF, 32'd1, 0);
    run_op(2'b01, 3'b101, 7'h20, 32'd0, 32'd1, 1);

    // reset while shifting
    @(negedge clk);
    alu_op = 2'b10; funct3 = 3'b001; funct7 = 7'h00; in_a = 32'h1234_5678; in_b = 32'd20;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 nreset = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_zero", 32'(zero), 32'd1);
    check("midrst_illegal", 32'(illegal), 32'd0);
    @(negedge clk); nreset = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_stale", 32'(seen), 32'd0);
    out_ready = 1'b0;

    // backpressure with a second request waiting
    @(negedge clk);
    alu_op = 2'b00; funct3 = 3'b000; funct7 = 7'h00; in_a = 32'd3; in_b = 32'd4;
    in_valid = 1'b1;
    @(posedge clk); #1;
    alu_op = 2'b10; funct3 = 3'b100; funct7 = 7'h00; in_a = 32'h0000_F0F0; in_b = 32'h0000_FF0F;
    check("bp_out_valid", 32'(out_valid), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp_result", result, 32'd7);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_ov", 32'(out_valid), 32'd0);
    check("bp_release_ir", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_next_ov", 32'(out_valid), 32'd1);
    check("bp_next_result", result, 32'h0000_0FFF);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // random
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    f7r = 7'h00;
        2:       f7r = 7'h20;
        default: f7r = 7'($urandom);
      endcase
      br = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      run_op(2'($urandom_range(0, 3)), 3'($urandom), f7r, $urandom, br,
             int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
